// File: rtl/ads_line_packer.sv
// Pairs ADS A/B channel samples into {B,A} pixel words, frames them into AFE lines
// and streams them out of a first-word-fall-through FIFO with sticky error flags.
module ads_line_packer #(
    parameter int DW             = 16,
    parameter int PAIRS_PER_LINE = 32,
    parameter int FIFO_AW        = 6,
    parameter int LCNT_W         = 16
) (
    input  logic              CLK_100M,
    input  logic              CLK_RST,
    input  logic              LINE_START,
    input  logic [DW-1:0]     ADS_ADATA,
    input  logic              ADS_AVLAID,
    input  logic [DW-1:0]     ADS_BDATA,
    input  logic              ADS_BVLAID,
    output logic [2*DW-1:0]   PIX_TDATA,
    output logic              PIX_TFIRST,
    output logic              PIX_TLAST,
    output logic              PIX_TVALID,
    input  logic              PIX_TREADY,
    output logic [LCNT_W-1:0] LINE_CNT,
    output logic [2:0]        STATUS,
    input  logic              ERR_CLR
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW    = (PAIRS_PER_LINE > 1) ? $clog2(PAIRS_PER_LINE) : 1;
    localparam int EW    = 2 * DW + 2;
    localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(DEPTH);
    localparam logic [CW-1:0]    LAST_IDX = CW'(PAIRS_PER_LINE - 1);

    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

    state_t              state;
    state_t              state_nxt;
    logic                active;
    logic                a_st, b_st, pair, pair_first, pair_last, a_err, b_err;
    logic                a_f, b_f;
    logic [DW-1:0]       a_hold, b_hold;
    logic [CW-1:0]       pair_cnt;
    logic [LCNT_W-1:0]   line_cnt;
    logic [2:0]          status;
    logic                vld_p0;
    logic [EW-1:0]       word_p0;
    logic [EW-1:0]       mem [DEPTH];
    logic [FIFO_AW-1:0]  wr_ptr, rd_ptr;
    logic [FIFO_AW:0]    count;
    logic                full, push, pop, ovf_set;
    logic [EW-1:0]       head;

    always_ff @(posedge CLK_100M or posedge CLK_RST) begin
        if (CLK_RST) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (LINE_START) state_nxt = ACTIVE;
            ACTIVE:  if (LINE_START) state_nxt = ACTIVE;
                     else if (pair && pair_last) state_nxt = DONE;
            DONE:    if (LINE_START) state_nxt = ACTIVE;
            default: state_nxt = IDLE;
        endcase
    end

    // Strobes only count inside a line and never on the cycle a line (re)starts.
    always_comb begin
        active = (state == ACTIVE) && !LINE_START;
    end

    assign a_st       = active & ADS_AVLAID;
    assign b_st       = active & ADS_BVLAID;
    assign pair       = (a_f | a_st) & (b_f | b_st);
    assign pair_first = (pair_cnt == '0);
    assign pair_last  = (pair_cnt == LAST_IDX);
    assign a_err      = a_st & a_f & ~b_f;
    assign b_err      = b_st & b_f & ~a_f;

    always_ff @(posedge CLK_100M or posedge CLK_RST) begin
        if (CLK_RST) begin
            a_f      <= 1'b0;
            b_f      <= 1'b0;
            pair_cnt <= '0;
            line_cnt <= '0;
            vld_p0   <= 1'b0;
        end else begin
            vld_p0 <= pair;
            if (LINE_START) begin
                a_f      <= 1'b0;
                b_f      <= 1'b0;
                pair_cnt <= '0;
            end else if (pair) begin
                a_f      <= 1'b0;
                b_f      <= 1'b0;
                pair_cnt <= pair_last ? '0 : pair_cnt + 1'b1;
                if (pair_last) line_cnt <= line_cnt + 1'b1;
            end else begin
                if (a_st) a_f <= 1'b1;
                if (b_st) b_f <= 1'b1;
            end
        end
    end

    // Stage p0: formed pair registered ahead of the FIFO write.
    always_ff @(posedge CLK_100M) begin
        if (a_st) a_hold <= ADS_ADATA;
        if (b_st) b_hold <= ADS_BDATA;
        if (pair) word_p0 <= {pair_last, pair_first,
                              b_st ? ADS_BDATA : b_hold,
                              a_st ? ADS_ADATA : a_hold};
    end

    // A full FIFO still accepts a write when the head is leaving the same cycle.
    assign full    = (count == FULL_CNT);
    assign pop     = (count != '0) & PIX_TREADY;
    assign push    = vld_p0 & (~full | pop);
    assign ovf_set = vld_p0 & full & ~pop;

    always_ff @(posedge CLK_100M or posedge CLK_RST) begin
        if (CLK_RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK_100M) begin
        if (push) mem[wr_ptr] <= word_p0;
    end

    always_ff @(posedge CLK_100M or posedge CLK_RST) begin
        if (CLK_RST) status <= 3'b000;
        else status <= (ERR_CLR ? 3'b000 : status)
                     | {LINE_START & (state == ACTIVE), a_err | b_err, ovf_set};
    end

    assign head       = mem[rd_ptr];
    assign PIX_TVALID = (count != '0);
    assign {PIX_TLAST, PIX_TFIRST, PIX_TDATA} = PIX_TVALID ? head : '0;
    assign LINE_CNT   = line_cnt;
    assign STATUS     = status;

endmodule

// File: tb/tb_ads_line_packer.sv
// Directed bench for ads_line_packer: scoreboard of expected pixel words checked
// on every output handshake, plus direct checks of status, counters and latency.
module tb_ads_line_packer;
    localparam int DW      = 16;
    localparam int PPL     = 32;
    localparam int FIFO_AW = 6;
    localparam int LCNT_W  = 16;

    logic              CLK_100M = 1'b0;
    logic              CLK_RST = 1'b1;
    logic              LINE_START = 1'b0;
    logic [DW-1:0]     ADS_ADATA = '0;
    logic              ADS_AVLAID = 1'b0;
    logic [DW-1:0]     ADS_BDATA = '0;
    logic              ADS_BVLAID = 1'b0;
    logic [2*DW-1:0]   PIX_TDATA;
    logic              PIX_TFIRST;
    logic              PIX_TLAST;
    logic              PIX_TVALID;
    logic              PIX_TREADY = 1'b1;
    logic [LCNT_W-1:0] LINE_CNT;
    logic [2:0]        STATUS;
    logic              ERR_CLR = 1'b0;

    always #5 CLK_100M = ~CLK_100M;

    ads_line_packer #(.DW(DW), .PAIRS_PER_LINE(PPL), .FIFO_AW(FIFO_AW), .LCNT_W(LCNT_W)) dut (
        .CLK_100M(CLK_100M), .CLK_RST(CLK_RST), .LINE_START(LINE_START),
        .ADS_ADATA(ADS_ADATA), .ADS_AVLAID(ADS_AVLAID),
        .ADS_BDATA(ADS_BDATA), .ADS_BVLAID(ADS_BVLAID),
        .PIX_TDATA(PIX_TDATA), .PIX_TFIRST(PIX_TFIRST), .PIX_TLAST(PIX_TLAST),
        .PIX_TVALID(PIX_TVALID), .PIX_TREADY(PIX_TREADY),
        .LINE_CNT(LINE_CNT), .STATUS(STATUS), .ERR_CLR(ERR_CLR)
    );

    logic [2*DW+1:0] sbq[$];
    logic [2*DW+1:0] mon_exp;
    int vectors = 0;
    int miscompares = 0;
    int pop_cnt = 0;
    int exp_idx = 0;
    int pops_before;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge CLK_100M) begin
        if (!CLK_RST && PIX_TVALID && PIX_TREADY) begin
            pop_cnt++;
            check("word_pending", 64'(sbq.size() > 0), 64'(1));
            if (sbq.size() > 0) begin
                mon_exp = sbq.pop_front();
                check("pix_word", 64'({PIX_TLAST, PIX_TFIRST, PIX_TDATA}), 64'(mon_exp));
            end
        end
    end

    task automatic tick();
        @(posedge CLK_100M);
        #1;
    endtask

    task automatic line_start();
        LINE_START = 1'b1;
        tick();
        LINE_START = 1'b0;
        exp_idx = 0;
    endtask

    task automatic err_clr();
        ERR_CLR = 1'b1;
        tick();
        ERR_CLR = 1'b0;
    endtask

    task automatic strobe(input bit sa, input bit sb, input logic [DW-1:0] a, input logic [DW-1:0] b);
        ADS_AVLAID = sa;
        ADS_BVLAID = sb;
        ADS_ADATA  = a;
        ADS_BDATA  = b;
        tick();
        ADS_AVLAID = 1'b0;
        ADS_BVLAID = 1'b0;
    endtask

    task automatic expect_word(input logic [DW-1:0] a, input logic [DW-1:0] b, input bit keep);
        logic f, l;
        f = (exp_idx == 0);
        l = (exp_idx == PPL - 1);
        if (keep) sbq.push_back({l, f, b, a});
        exp_idx = l ? 0 : exp_idx + 1;
    endtask

    task automatic send_pair(input logic [DW-1:0] a, input logic [DW-1:0] b, input bit keep);
        strobe(1'b1, 1'b1, a, b);
        expect_word(a, b, keep);
    endtask

    task automatic send_line(input bit keep);
        for (int i = 0; i < PPL; i++) send_pair(DW'($urandom), DW'($urandom), keep);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((sbq.size() != 0 || PIX_TVALID) && n < budget) begin
            tick();
            n++;
        end
        check("drain_in_budget", 64'(n < budget), 64'(1));
    endtask

    initial begin
        // reset state
        repeat (3) @(posedge CLK_100M);
        #1;
        check("rst_outputs", 64'({PIX_TVALID, PIX_TFIRST, PIX_TLAST, PIX_TDATA}), 64'(0));
        check("rst_status", 64'(STATUS), 64'(0));
        check("rst_line_cnt", 64'(LINE_CNT), 64'(0));
        CLK_RST = 1'b0;
        tick();

        // strobes before any LINE_START are ignored
        send_pair(16'h1234, 16'h5678, 1'b0);
        exp_idx = 0;
        repeat (3) tick();
        check("idle_ignored", 64'(PIX_TVALID), 64'(0));

        // full line, ramp pattern
        line_start();
        for (int i = 0; i < PPL; i++) send_pair(DW'(i), DW'(16'h8000 + i), 1'b1);
        check("line_cnt_1", 64'(LINE_CNT), 64'(1));
        wait_drain(200);
        check("status_clean", 64'(STATUS), 64'(0));

        // pairing latency: simultaneous strobes, then A three cycles before B
        line_start();
        send_pair(16'h00A1, 16'h00B1, 1'b1);
        check("lat_sim_n1", 64'(PIX_TVALID), 64'(0));
        tick();
        check("lat_sim_n2", 64'(PIX_TVALID), 64'(1));
        wait_drain(20);
        strobe(1'b1, 1'b0, 16'h00A2, 16'h0);
        tick();
        tick();
        strobe(1'b0, 1'b1, 16'h0, 16'h00B2);
        expect_word(16'h00A2, 16'h00B2, 1'b1);
        check("lat_split_n1", 64'(PIX_TVALID), 64'(0));
        tick();
        check("lat_split_n2", 64'(PIX_TVALID), 64'(1));
        wait_drain(20);

        // A overwrite before B arrives
        strobe(1'b1, 1'b0, 16'h0011, 16'h0);
        strobe(1'b1, 1'b0, 16'h0022, 16'h0);
        strobe(1'b0, 1'b1, 16'h0, 16'h0033);
        expect_word(16'h0022, 16'h0033, 1'b1);
        check("pair_err", 64'(STATUS), 64'(3'b010));
        wait_drain(20);
        err_clr();
        check("pair_err_clr", 64'(STATUS), 64'(0));

        // line restarted after 10 pairs
        for (int i = 3; i < 10; i++) send_pair(DW'($urandom), DW'($urandom), 1'b1);
        line_start();
        check("short_line", 64'(STATUS), 64'(3'b100));
        check("short_line_cnt", 64'(LINE_CNT), 64'(1));
        send_line(1'b1);
        check("line_cnt_2", 64'(LINE_CNT), 64'(2));
        wait_drain(200);
        err_clr();
        check("short_clr", 64'(STATUS), 64'(0));

        // overflow: three lines with the consumer stalled
        PIX_TREADY = 1'b0;
        for (int l = 0; l < 3; l++) begin
            line_start();
            for (int i = 0; i < PPL; i++)
                send_pair(DW'($urandom), DW'($urandom), (l * PPL + i) < (1 << FIFO_AW));
        end
        repeat (2) tick();
        check("ovf_status", 64'(STATUS), 64'(3'b001));
        check("ovf_valid", 64'(PIX_TVALID), 64'(1));
        check("ovf_head_hold", 64'({PIX_TLAST, PIX_TFIRST, PIX_TDATA}), 64'(sbq[0]));
        check("line_cnt_5", 64'(LINE_CNT), 64'(5));
        pops_before = pop_cnt;
        PIX_TREADY = 1'b1;
        wait_drain(200);
        check("ovf_drain_cnt", 64'(pop_cnt - pops_before), 64'(1 << FIFO_AW));
        err_clr();
        check("ovf_clr", 64'(STATUS), 64'(0));

        // write into a full FIFO on the cycle the head is popped
        PIX_TREADY = 1'b0;
        line_start();
        send_line(1'b1);
        line_start();
        send_line(1'b1);
        line_start();
        send_pair(16'hCAFE, 16'hBEEF, 1'b1);
        PIX_TREADY = 1'b1;
        for (int i = 1; i < PPL; i++) send_pair(DW'($urandom), DW'($urandom), 1'b1);
        wait_drain(300);
        check("full_pop_no_ovf", 64'(STATUS), 64'(0));
        check("line_cnt_8", 64'(LINE_CNT), 64'(8));

        // reset mid-line with the FIFO half full and a sticky flag set
        PIX_TREADY = 1'b0;
        line_start();
        for (int i = 0; i < 10; i++) send_pair(DW'($urandom), DW'($urandom), 1'b0);
        line_start();
        for (int i = 0; i < 22; i++) send_pair(DW'($urandom), DW'($urandom), 1'b0);
        check("pre_rst_status", 64'(STATUS), 64'(3'b100));
        CLK_RST = 1'b1;
        #1;
        check("rst_mid_valid", 64'(PIX_TVALID), 64'(0));
        check("rst_mid_status", 64'(STATUS), 64'(0));
        check("rst_mid_line_cnt", 64'(LINE_CNT), 64'(0));
        sbq.delete();
        tick();
        CLK_RST = 1'b0;
        PIX_TREADY = 1'b1;
        tick();
        send_pair(16'h0BAD, 16'h0BAD, 1'b0);
        repeat (3) tick();
        check("post_rst_ignored", 64'(PIX_TVALID), 64'(0));
        line_start();
        send_pair(16'h0F00, 16'h0F01, 1'b1);
        wait_drain(20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
